// File: rtl/vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_sequencer
// Brief    : Coin pulse conditioning and physical vend sequencing around the
//            coffee-vending FSM (motor run, change ejection, FSM clear).
// Revision : 1.0
// ============================================================================
module vend_sequencer #(
  parameter int MOTOR_CYCLES = 8,
  parameter int DROP_CYCLES  = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin_in_50,
  input  logic        coin_in_100,
  input  logic        coin_in_200,
  input  logic        fsm_cafe,
  input  logic        fsm_t50,
  input  logic        fsm_t100,
  input  logic        fsm_t200,
  input  logic [3:0]  fsm_state,
  output logic        fsm_r50,
  output logic        fsm_r100,
  output logic        fsm_r200,
  output logic        fsm_clr,
  output logic        accept_en,
  output logic        motor_on,
  output logic        drop_50,
  output logic        drop_100,
  output logic        coin_reject,
  output logic [15:0] sold_count
);

  localparam int c_MAX_DG  = (DROP_CYCLES > GAP_CYCLES) ? DROP_CYCLES : GAP_CYCLES;
  localparam int c_CNT_MAX = (MOTOR_CYCLES > c_MAX_DG) ? MOTOR_CYCLES : c_MAX_DG;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_CNT_W-1:0] c_MOTOR_LAST = c_CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DROP_LAST  = c_CNT_W'(DROP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  // No transition between two non-CLEAR states passes through 2'b10, so the
  // decoded fsm_clr (an asynchronous clear downstream) cannot glitch.
  localparam logic [1:0] c_ST_ACCEPT = 2'b00;
  localparam logic [1:0] c_ST_VEND   = 2'b01;
  localparam logic [1:0] c_ST_CHANGE = 2'b11;
  localparam logic [1:0] c_ST_CLEAR  = 2'b10;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [2:0]         r_prev;
  logic [2:0]         r_pend;
  logic [2:0]         r_issue;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_drop_hi;
  logic [2:0]         r_units;
  logic [15:0]        r_sold_count;

  logic [2:0]         w_coin;
  logic [2:0]         w_edge;
  logic               w_accept;
  logic               w_can_issue;
  logic [2:0]         w_pick;
  logic [2:0]         w_pend_nxt;
  logic               w_units_ge2;
  logic               w_unused_state;

  // The sequencer never needs the FSM's state word itself.
  assign w_unused_state = ^fsm_state;

  assign w_coin      = {coin_in_200, coin_in_100, coin_in_50};
  assign w_edge      = w_coin & ~r_prev;
  assign w_accept    = (r_state == c_ST_ACCEPT);
  assign w_units_ge2 = |r_units[2:1];
  // A pulse is never issued while the previous one is still high, which
  // leaves a blank cycle for fsm_cafe to settle before the next decision.
  assign w_can_issue = w_accept & ~fsm_cafe & ~(|r_issue);

  always_comb begin
    w_pick = 3'b000;
    if (w_can_issue) begin
      if (r_pend[0])      w_pick = 3'b001;
      else if (r_pend[1]) w_pick = 3'b010;
      else if (r_pend[2]) w_pick = 3'b100;
    end
  end

  always_comb begin
    w_pend_nxt = 3'b000;
    if (w_accept && !fsm_cafe) begin
      w_pend_nxt = (r_pend & ~w_pick) | w_edge;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_ACCEPT: begin
        if (fsm_cafe) w_state_nxt = c_ST_VEND;
      end
      c_ST_VEND: begin
        if (r_cnt == c_MOTOR_LAST) begin
          w_state_nxt = (r_units == 3'd0) ? c_ST_CLEAR : c_ST_CHANGE;
        end
      end
      c_ST_CHANGE: begin
        if (!r_drop_hi && (r_cnt == c_GAP_LAST) && (r_units == 3'd0)) begin
          w_state_nxt = c_ST_CLEAR;
        end
      end
      c_ST_CLEAR: w_state_nxt = c_ST_ACCEPT;
      default:    w_state_nxt = c_ST_ACCEPT;
    endcase
  end

  // Coin conditioning, timing counter, change units and sales counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev       <= 3'b000;
      r_pend       <= 3'b000;
      r_issue      <= 3'b000;
      r_cnt        <= '0;
      r_drop_hi    <= 1'b0;
      r_units      <= 3'd0;
      r_sold_count <= 16'd0;
    end else begin
      r_prev  <= w_coin;
      r_pend  <= w_pend_nxt;
      r_issue <= w_pick;
      case (r_state)
        c_ST_ACCEPT: begin
          if (fsm_cafe) begin
            // Change in 50-units: t50 + 2*t100 + 4*t200 is the flags as binary.
            r_units <= {fsm_t200, fsm_t100, fsm_t50};
            r_cnt   <= '0;
            if (r_sold_count != 16'hFFFF) begin
              r_sold_count <= r_sold_count + 16'd1;
            end
          end
        end
        c_ST_VEND: begin
          if (r_cnt == c_MOTOR_LAST) begin
            r_cnt     <= '0;
            r_drop_hi <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_CHANGE: begin
          if (r_drop_hi) begin
            if (r_cnt == c_DROP_LAST) begin
              r_cnt     <= '0;
              r_drop_hi <= 1'b0;
              r_units   <= w_units_ge2 ? (r_units - 3'd2) : (r_units - 3'd1);
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end else begin
            if (r_cnt == c_GAP_LAST) begin
              r_cnt     <= '0;
              r_drop_hi <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Output decode
  always_comb begin
    accept_en   = 1'b0;
    motor_on    = 1'b0;
    fsm_clr     = 1'b0;
    drop_50     = 1'b0;
    drop_100    = 1'b0;
    case (r_state)
      c_ST_ACCEPT: accept_en = 1'b1;
      c_ST_VEND:   motor_on  = 1'b1;
      c_ST_CHANGE: begin
        drop_100 = r_drop_hi & w_units_ge2;
        drop_50  = r_drop_hi & (r_units == 3'd1);
      end
      c_ST_CLEAR:  fsm_clr   = 1'b1;
      default:     accept_en = 1'b0;
    endcase
    // An edge landing on its own issue cycle re-arms the flag, so it is kept.
    coin_reject = w_accept ? |(w_edge & r_pend & ~w_pick) : |w_edge;
  end

  assign fsm_r50    = r_issue[0];
  assign fsm_r100   = r_issue[1];
  assign fsm_r200   = r_issue[2];
  assign sold_count = r_sold_count;

endmodule
`default_nettype wire

// File: tb/tb_vend_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_sequencer
// Brief    : Directed vector bench for vend_sequencer with a small vending FSM.
// Revision : 1.0
// ============================================================================
module tb_vend_sequencer;

  logic        clk;
  logic        rst;
  logic        coin_in_50, coin_in_100, coin_in_200;
  logic        fsm_cafe, fsm_t50, fsm_t100, fsm_t200;
  logic [3:0]  fsm_state;
  logic        fsm_r50, fsm_r100, fsm_r200, fsm_clr;
  logic        accept_en, motor_on, drop_50, drop_100, coin_reject;
  logic [15:0] sold_count;

  vend_sequencer #(
    .MOTOR_CYCLES(8),
    .DROP_CYCLES (2),
    .GAP_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_in_50 (coin_in_50),
    .coin_in_100(coin_in_100),
    .coin_in_200(coin_in_200),
    .fsm_cafe   (fsm_cafe),
    .fsm_t50    (fsm_t50),
    .fsm_t100   (fsm_t100),
    .fsm_t200   (fsm_t200),
    .fsm_state  (fsm_state),
    .fsm_r50    (fsm_r50),
    .fsm_r100   (fsm_r100),
    .fsm_r200   (fsm_r200),
    .fsm_clr    (fsm_clr),
    .accept_en  (accept_en),
    .motor_on   (motor_on),
    .drop_50    (drop_50),
    .drop_100   (drop_100),
    .coin_reject(coin_reject),
    .sold_count (sold_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vending FSM: credit in 50-units, cafe at >=250, change flags from excess.
  logic [3:0] m_state;
  logic [3:0] m_chg;
  logic       m_clr;
  logic       m_cafe;
  assign m_clr  = rst | fsm_clr;
  assign m_cafe = (m_state >= 4'd5);
  assign m_chg  = m_state - 4'd5;
  always_ff @(posedge clk or posedge m_clr) begin
    if (m_clr) m_state <= 4'd0;
    else if (!m_cafe) m_state <= m_state + {1'b0, fsm_r200, fsm_r100, fsm_r50};
  end
  assign fsm_cafe  = m_cafe;
  assign fsm_t50   = m_cafe & m_chg[0];
  assign fsm_t100  = m_cafe & m_chg[1];
  assign fsm_t200  = m_cafe & m_chg[2];
  assign fsm_state = m_state;

  // {fsm_r50, fsm_r100, fsm_r200, fsm_clr, accept_en, motor_on, drop_50, drop_100, coin_reject}
  logic [8:0] obs;
  assign obs = {fsm_r50, fsm_r100, fsm_r200, fsm_clr, accept_en, motor_on,
                drop_50, drop_100, coin_reject};

  localparam logic [8:0] IDLE = 9'b000000000;
  localparam logic [8:0] ACC  = 9'b000010000;
  localparam logic [8:0] RJA  = 9'b000010001;
  localparam logic [8:0] R50  = 9'b100010000;
  localparam logic [8:0] R100 = 9'b010010000;
  localparam logic [8:0] R200 = 9'b001010000;
  localparam logic [8:0] MOT  = 9'b000001000;
  localparam logic [8:0] CLR  = 9'b000100000;
  localparam logic [8:0] D50  = 9'b000000100;
  localparam logic [8:0] D100 = 9'b000000010;

  // coins field is {coin_in_50, coin_in_100, coin_in_200}
  typedef struct {
    logic [2:0] coins;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [2:0] c, input logic [8:0] e, input int n);
    vec_t v;
    v.coins = c;
    v.exp   = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Drive coins at cycle start, sample at the falling edge, return at next cycle start.
  task automatic cyc(input logic [2:0] c, output logic [8:0] o);
    {coin_in_50, coin_in_100, coin_in_200} = c;
    @(negedge clk);
    o = obs;
    @(posedge clk);
    #1;
  endtask

  task automatic vend250;
    logic [8:0] o;
    cyc(3'b001, o);
    repeat (3) cyc(3'b000, o);
    cyc(3'b100, o);
    repeat (12) cyc(3'b000, o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] o;
    rst = 1'b1;
    {coin_in_50, coin_in_100, coin_in_200} = 3'b000;

    // 200 then 50 -> 250, no change
    add(3'b001, ACC, 1); add(3'b000, ACC, 1); add(3'b000, R200, 1); add(3'b000, ACC, 1);
    add(3'b100, ACC, 1); add(3'b000, ACC, 1); add(3'b000, R50, 1);  add(3'b000, ACC, 1);
    add(3'b000, MOT, 8); add(3'b000, CLR, 1); add(3'b000, ACC, 1);
    // 200, 200 -> 400: change 150 = one 100 then one 50
    add(3'b001, ACC, 1); add(3'b000, ACC, 1); add(3'b001, R200, 1); add(3'b000, ACC, 1);
    add(3'b000, R200, 1); add(3'b000, ACC, 1); add(3'b000, MOT, 8);
    add(3'b000, D100, 2); add(3'b000, IDLE, 2); add(3'b000, D50, 2); add(3'b000, IDLE, 2);
    add(3'b000, CLR, 1); add(3'b000, ACC, 1);
    // all three at once -> issued k+2, k+4, k+6; 350 -> one 100 drop
    add(3'b111, ACC, 1); add(3'b000, ACC, 1); add(3'b000, R50, 1);  add(3'b000, ACC, 1);
    add(3'b000, R100, 1); add(3'b000, ACC, 1); add(3'b000, R200, 1); add(3'b000, ACC, 1);
    add(3'b000, MOT, 8); add(3'b000, D100, 2); add(3'b000, IDLE, 2);
    add(3'b000, CLR, 1); add(3'b000, ACC, 1);
    // 50 re-edge on its issue cycle is kept; later a 50 re-edge in the cafe cycle is rejected
    add(3'b010, ACC, 1); add(3'b100, ACC, 1); add(3'b000, R100, 1); add(3'b100, ACC, 1);
    add(3'b000, R50, 1);  add(3'b000, ACC, 1); add(3'b000, R50, 1);  add(3'b010, ACC, 1);
    add(3'b100, ACC, 1); add(3'b000, R100, 1); add(3'b100, RJA, 1);
    add(3'b000, MOT, 8); add(3'b000, D50, 2); add(3'b000, IDLE, 2);
    add(3'b000, CLR, 1); add(3'b000, ACC, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", obs, ACC);
    chk("reset_sold", sold_count, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].coins, o);
      chk($sformatf("vec%0d", i), o, tbl[i].exp);
    end
    chk("table_sold", sold_count, 16'd4);
    chk("table_fsm_state", fsm_state, 4'd0);

    // coin edge while the motor runs
    cyc(3'b001, o);
    repeat (3) cyc(3'b000, o);
    cyc(3'b100, o);
    repeat (3) cyc(3'b000, o);
    for (int i = 8; i <= 16; i++) begin
      cyc((i == 10) ? 3'b010 : 3'b000, o);
      chk($sformatf("vend_cyc%0d", i), o, (i == 16) ? CLR : ((i == 10) ? (MOT | 9'b1) : MOT));
      if (i == 10) chk("vend_fsm_state", fsm_state, 4'd5);
    end
    @(negedge clk);
    chk("vend_accept", obs, ACC);
    chk("vend_fsm_cleared", fsm_state, 4'd0);
    chk("vend_sold", sold_count, 16'd5);
    @(posedge clk);
    #1;

    // reset in the middle of a change drop
    cyc(3'b001, o);
    cyc(3'b000, o);
    cyc(3'b001, o);
    repeat (11) cyc(3'b000, o);
    cyc(3'b000, o);
    chk("change_drop100", o, D100);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_outputs", obs, ACC);
    chk("rst_sold", sold_count, 16'd0);
    chk("rst_fsm_state", fsm_state, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // saturation of the sales counter
    force dut.r_sold_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_sold_count;
    @(posedge clk);
    #1;
    vend250();
    @(negedge clk);
    chk("sat_reach", sold_count, 16'hFFFF);
    @(posedge clk);
    #1;
    vend250();
    @(negedge clk);
    chk("sat_hold", sold_count, 16'hFFFF);
    chk("sat_accept", obs, ACC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
